data_mem_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory request interface.
- Accepts one load or store request at a time over a valid/ready handshake and performs it against an internal 2^ADDR_WIDTH-byte, little-endian, word-organised RAM after a fixed latency.
- Returns read data, a tag and an error flag over a valid/ready response channel.
- Sits between the load/store issue logic and the ROB/complete logic, replacing the zero-latency memory model with one that exercises stalls and backpressure.

---
 rtl/data_mem_if.sv | 39 +++
 rtl/data_mem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Data-memory request/response channel between the load/store issue logic
// (master) and the memory responder (slave). Both directions use valid/ready.
interface data_mem_if #(
    parameter int TAG_WIDTH = 6
);
    // Request channel
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic [TAG_WIDTH-1:0] req_tag;

    // Response channel
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_rdata;
    logic [TAG_WIDTH-1:0] resp_tag;
    logic                 resp_is_store;
    logic                 resp_error;

    // Load/store issue side
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_tag,
        output resp_ready,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_tag, resp_is_store, resp_error
    );

    // Memory side
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_tag,
        input  resp_ready,
        output req_ready,
        output resp_valid, resp_rdata, resp_tag, resp_is_store, resp_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder for the data-memory request interface.
// Accepts one load/store at a time, performs it against an internal
// little-endian word-organised RAM after a fixed latency, and returns
// extended read data, the echoed tag and an error flag.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 15,  // byte-address bits implemented
    parameter int LATENCY    = 2,   // accept-to-resp_valid cycles, 1..15
    parameter int TAG_WIDTH  = 6
) (
    input  logic      clk,
    input  logic      reset,
    data_mem_if.slave bus
);

    localparam int IDX_WIDTH = ADDR_WIDTH - 2;
    localparam int WORDS     = 1 << IDX_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_t;

    // Request fields captured at accept; the bus is not looked at again.
    typedef struct packed {
        logic                 we;
        size_t                size;
        logic                 is_unsigned;
        logic [31:0]          addr;
        logic [31:0]          wdata;
        logic [TAG_WIDTH-1:0] tag;
    } req_t;

    state_t               state;
    logic [3:0]           counter;
    req_t                 req_q;

    logic                 req_ready_q;
    logic                 resp_valid_q;
    logic [31:0]          resp_rdata_q;
    logic [TAG_WIDTH-1:0] resp_tag_q;
    logic                 resp_is_store_q;
    logic                 resp_error_q;

    logic [31:0]          mem [WORDS];

    logic [IDX_WIDTH-1:0] word_idx;
    logic                 misaligned;
    logic                 out_of_range;
    logic                 access_error;
    logic                 access_now;
    logic                 mem_we;

    logic [31:0]          rd_word;
    logic [7:0]           rd_byte;
    logic [15:0]          rd_half;
    logic [31:0]          load_data;

    logic [3:0]           byte_en;
    logic [31:0]          wr_lanes;
    logic [31:0]          wr_word;

    assign word_idx   = req_q.addr[ADDR_WIDTH-1:2];
    assign access_now = (state == BUSY) && (counter == 4'd0);
    // A reset arriving on the access edge aborts the store with no RAM write.
    assign mem_we     = access_now && req_q.we && !access_error && !reset;

    // Classify the captured request: illegal size, misalignment, address range.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        misaligned = 1'b0;
        case (req_q.size)
            SIZE_HALF: misaligned = req_q.addr[0];
            SIZE_WORD: misaligned = |req_q.addr[1:0];
            default:   misaligned = 1'b0;
        endcase
        out_of_range = (req_q.addr >> ADDR_WIDTH) != 32'd0;
        access_error = (req_q.size == SIZE_ILLEGAL) || misaligned || out_of_range;
    end

    // Read the addressed word and extract/extend the requested lane.
    always_comb begin
        rd_word = mem[word_idx];
        rd_byte = rd_word[7:0];
        case (req_q.addr[1:0])
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
        endcase
        rd_half = req_q.addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (req_q.size)
            SIZE_BYTE: load_data = {{24{rd_byte[7] & ~req_q.is_unsigned}}, rd_byte};
            SIZE_HALF: load_data = {{16{rd_half[15] & ~req_q.is_unsigned}}, rd_half};
            default:   load_data = rd_word;
        endcase
    end

    // Build the merged store word: replicate data across lanes, then keep
    // only the enabled lanes and preserve the rest from the current word.
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = req_q.wdata;
        case (req_q.size)
            SIZE_BYTE: begin
                byte_en  = 4'b0001 << req_q.addr[1:0];
                wr_lanes = {4{req_q.wdata[7:0]}};
            end
            SIZE_HALF: begin
                byte_en  = req_q.addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{req_q.wdata[15:0]}};
            end
            SIZE_WORD: byte_en = 4'b1111;
            default:   byte_en = 4'b0000;
        endcase
        wr_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = byte_en[i] ? wr_lanes[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

    // RAM write port; the write lands on the BUSY->RESP edge only.
    // NOTE: the RAM array is deliberately left out of reset so it maps onto
    // memory macros; only control state is reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= wr_word;
        end
    end

    // Control FSM: accept, count down the latency, present and hold the response.
    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            counter         <= 4'd0;
            req_q           <= '0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'd0;
            resp_tag_q      <= '0;
            resp_is_store_q <= 1'b0;
            resp_error_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_q.we          <= bus.req_we;
                        req_q.size        <= size_t'(bus.req_size);
                        req_q.is_unsigned <= bus.req_unsigned;
                        req_q.addr        <= bus.req_addr;
                        req_q.wdata       <= bus.req_wdata;
                        req_q.tag         <= bus.req_tag;
                        counter           <= 4'(LATENCY - 1);
                        req_ready_q       <= 1'b0;
                        state             <= BUSY;
                    end
                end
                BUSY: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else begin
                        resp_valid_q    <= 1'b1;
                        resp_rdata_q    <= (req_q.we || access_error) ? 32'd0 : load_data;
                        resp_tag_q      <= req_q.tag;
                        resp_is_store_q <= req_q.we;
                        resp_error_q    <= access_error;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_tag      = resp_tag_q;
    assign bus.resp_is_store = resp_is_store_q;
    assign bus.resp_error    = resp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. Two instances (LATENCY 2 and 1)
// share one set of stimulus signals; `sel` chooses which one is driven and
// observed. Expected responses come from a byte-array reference model and are
// queued at issue; a monitor pops and compares at each response handshake.
module tb_data_mem_responder;

    localparam int TW = 6;

    typedef struct {
        logic [31:0]   rdata;
        logic [TW-1:0] tag;
        bit            is_store;
        bit            err;
        int            rise_edge;
    } exp_t;

    logic          clk;
    logic          reset;
    bit            sel;
    logic          req_valid;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [TW-1:0] req_tag;
    logic          resp_ready;

    bit            rr_random;
    bit            rr_fixed;

    logic          m_req_ready;
    logic          m_resp_valid;
    logic [31:0]   m_resp_rdata;
    logic [TW-1:0] m_resp_tag;
    logic          m_resp_is_store;
    logic          m_resp_error;

    int            cyc;
    int            checks;
    int            errors;
    int            hs_edge;
    logic [31:0]   last_rdata;
    logic [TW-1:0] last_tag;
    logic          last_err;

    exp_t          sb[$];
    logic [7:0]    ref_mem [2][32768];
    logic [31:0]   init_data [128];

    data_mem_if #(.TAG_WIDTH(TW)) bus0 ();
    data_mem_if #(.TAG_WIDTH(TW)) bus1 ();

    data_mem_responder #(.ADDR_WIDTH(15), .LATENCY(2), .TAG_WIDTH(TW)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    data_mem_responder #(.ADDR_WIDTH(15), .LATENCY(1), .TAG_WIDTH(TW)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    assign bus0.req_valid    = req_valid & ~sel;
    assign bus0.req_we       = req_we;
    assign bus0.req_size     = req_size;
    assign bus0.req_unsigned = req_unsigned;
    assign bus0.req_addr     = req_addr;
    assign bus0.req_wdata    = req_wdata;
    assign bus0.req_tag      = req_tag;
    assign bus0.resp_ready   = resp_ready & ~sel;

    assign bus1.req_valid    = req_valid & sel;
    assign bus1.req_we       = req_we;
    assign bus1.req_size     = req_size;
    assign bus1.req_unsigned = req_unsigned;
    assign bus1.req_addr     = req_addr;
    assign bus1.req_wdata    = req_wdata;
    assign bus1.req_tag      = req_tag;
    assign bus1.resp_ready   = resp_ready & sel;

    assign m_req_ready     = sel ? bus1.req_ready     : bus0.req_ready;
    assign m_resp_valid    = sel ? bus1.resp_valid    : bus0.resp_valid;
    assign m_resp_rdata    = sel ? bus1.resp_rdata    : bus0.resp_rdata;
    assign m_resp_tag      = sel ? bus1.resp_tag      : bus0.resp_tag;
    assign m_resp_is_store = sel ? bus1.resp_is_store : bus0.resp_is_store;
    assign m_resp_error    = sel ? bus1.resp_error    : bus0.resp_error;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d, latency-%0d dut)",
                     name, act, exp, cyc, sel ? 1 : 2);
        end
    endtask

    // Reference model: byte-addressed memory, little-endian, with the access rules
    // applied directly to byte counts and address arithmetic.
    function automatic void model(input bit we, input logic [1:0] size, input bit uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output bit err);
        int          nbytes;
        int          base;
        logic [31:0] v;
        nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        err    = (size == 2'b11) || ((addr % nbytes) != 0) || (addr >= 32'd32768);
        rdata  = 32'd0;
        if (err) return;
        base = int'(addr[14:0]);
        if (we) begin
            for (int i = 0; i < nbytes; i++) ref_mem[sel][base + i] = wdata[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < nbytes; i++) v[8*i +: 8] = ref_mem[sel][base + i];
            if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
            rdata = v;
        end
    endfunction

    // Present a request, wait (bounded) for acceptance, and optionally queue
    // its expected response. acc returns the accepting edge number.
    task automatic send(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [TW-1:0] tag, input bit push, output int acc);
        int          n;
        logic [31:0] rd;
        bit          er;
        exp_t        e;
        n            = 0;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_tag      = tag;
        while (!m_req_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            check("req_accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            acc       = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
        if (push) begin
            model(we, size, uns, addr, wdata, rd, er);
            e.rdata     = rd;
            e.err       = er;
            e.tag       = tag;
            e.is_store  = we;
            e.rise_edge = acc + (sel ? 1 : 2);
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || m_resp_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready",     32'(m_req_ready),     32'd1);
        check("rst_resp_valid",    32'(m_resp_valid),    32'd0);
        check("rst_resp_rdata",    m_resp_rdata,         32'd0);
        check("rst_resp_tag",      32'(m_resp_tag),      32'd0);
        check("rst_resp_is_store", 32'(m_resp_is_store), 32'd0);
        check("rst_resp_error",    32'(m_resp_error),    32'd0);
    endtask

    // resp_ready driver: either a fixed level or random backpressure.
    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            resp_ready = rr_random ? ($urandom_range(0, 3) != 0) : rr_fixed;
        end
    end

    // Monitor: checks latency, hold-stability under backpressure, req_ready low
    // during the response, and pops the scoreboard at each handshake.
    initial begin
        bit            was_valid;
        int            rise;
        logic [31:0]   held_rdata;
        logic [31:0]   held_ctl;
        exp_t          e;
        was_valid = 1'b0;
        rise      = 0;
        forever begin
            @(negedge clk);
            if (reset || !m_resp_valid) begin
                was_valid = 1'b0;
            end else begin
                if (!was_valid) begin
                    was_valid  = 1'b1;
                    rise       = cyc;
                    held_rdata = m_resp_rdata;
                    held_ctl   = {24'd0, m_resp_tag, m_resp_is_store, m_resp_error};
                end else begin
                    check("hold_rdata", m_resp_rdata, held_rdata);
                    check("hold_ctl", {24'd0, m_resp_tag, m_resp_is_store, m_resp_error}, held_ctl);
                end
                check("req_ready_low_in_resp", 32'(m_req_ready), 32'd0);
                if (resp_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_response", 32'd0, 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check("resp_latency_edge", 32'(rise),           32'(e.rise_edge));
                        check("resp_rdata",        m_resp_rdata,        e.rdata);
                        check("resp_tag",          32'(m_resp_tag),     32'(e.tag));
                        check("resp_is_store",     32'(m_resp_is_store), 32'(e.is_store));
                        check("resp_error",        32'(m_resp_error),   32'(e.err));
                    end
                    last_rdata = m_resp_rdata;
                    last_tag   = m_resp_tag;
                    last_err   = m_resp_error;
                    hs_edge    = cyc + 1;
                    was_valid  = 1'b0;
                end
            end
        end
    end

    initial begin
        int            acc;
        int            acc2;
        int            acc_prev;
        int            n;
        int            r;
        logic [1:0]    size;
        logic [31:0]   a;

        checks       = 0;
        errors       = 0;
        hs_edge      = 0;
        sel          = 1'b0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        req_tag      = '0;
        rr_random    = 1'b0;
        rr_fixed     = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Fill 0x000..0x1FF with known words so every later load has defined data.
        for (int i = 0; i < 128; i++) begin
            init_data[i] = $urandom;
            send(1'b1, 2'b10, 1'b0, 32'(i * 4), init_data[i], 6'(i), 1'b1, acc);
        end
        wait_drain();

        // Reset in BUSY aborts the store: outputs return to reset values, RAM untouched.
        send(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 6'd1, 1'b0, acc);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        send(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 6'd2, 1'b1, acc);
        wait_drain();
        check("abort_keeps_prior_word", last_rdata, init_data[16]);

        // Word store/load and lane extension.
        send(1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, 6'd5, 1'b1, acc);
        wait_drain();
        check("store_tag_echo", 32'(last_tag), 32'd5);
        send(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 6'd6, 1'b1, acc);
        wait_drain();
        check("load_tag_echo", 32'(last_tag), 32'd6);
        check("load_word", last_rdata, 32'h12345678);
        send(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 6'd7, 1'b1, acc);
        wait_drain();
        check("load_byte_s_103", last_rdata, 32'h00000012);
        send(1'b1, 2'b00, 1'b0, 32'h101, 32'h00000080, 6'd8, 1'b1, acc);
        send(1'b0, 2'b00, 1'b0, 32'h101, 32'd0, 6'd9, 1'b1, acc);
        wait_drain();
        check("load_byte_s_101", last_rdata, 32'hFFFFFF80);
        send(1'b0, 2'b00, 1'b1, 32'h101, 32'd0, 6'd10, 1'b1, acc);
        wait_drain();
        check("load_byte_u_101", last_rdata, 32'h00000080);
        send(1'b0, 2'b01, 1'b0, 32'h102, 32'd0, 6'd11, 1'b1, acc);
        wait_drain();
        check("load_half_s_102", last_rdata, 32'h00001234);

        // Error cases: flagged, zero data, RAM unchanged.
        send(1'b0, 2'b01, 1'b0, 32'h101, 32'd0, 6'd12, 1'b1, acc);
        wait_drain();
        check("err_half_misaligned", {31'd0, last_err}, 32'd1);
        check("err_half_rdata", last_rdata, 32'd0);
        send(1'b1, 2'b10, 1'b0, 32'h102, 32'hCAFEF00D, 6'd13, 1'b1, acc);
        wait_drain();
        check("err_word_misaligned", {31'd0, last_err}, 32'd1);
        send(1'b0, 2'b10, 1'b0, 32'h8000, 32'd0, 6'd14, 1'b1, acc);
        wait_drain();
        check("err_out_of_range", {31'd0, last_err}, 32'd1);
        check("err_range_rdata", last_rdata, 32'd0);
        send(1'b0, 2'b11, 1'b0, 32'h100, 32'd0, 6'd15, 1'b1, acc);
        wait_drain();
        check("err_size_11", {31'd0, last_err}, 32'd1);
        send(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 6'd16, 1'b1, acc);
        wait_drain();
        check("word_after_byte_store", last_rdata, 32'h12348078);

        // Back-to-back issue interval with resp_ready held high.
        acc_prev = 0;
        for (int k = 0; k < 4; k++) begin
            send(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 6'(20 + k), 1'b1, acc);
            if (k > 0) check("issue_interval_lat2", 32'(acc - acc_prev), 32'd4);
            acc_prev = acc;
        end
        wait_drain();

        // Backpressure: hold resp_ready low for 5 cycles with a new request waiting.
        rr_fixed = 1'b0;
        @(posedge clk);
        #1;
        send(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 6'd30, 1'b1, acc);
        acc2 = -1;
        fork
            send(1'b0, 2'b10, 1'b0, 32'h104, 32'd0, 6'd31, 1'b1, acc2);
            begin
                n = 0;
                while (!m_resp_valid && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                if (n >= 50) check("bp_resp_timeout", 32'd0, 32'd1);
                repeat (5) @(posedge clk);
                #1;
                rr_fixed = 1'b1;
            end
        join
        check("bp_accept_after_handshake", 32'(acc2), 32'(hs_edge + 1));
        wait_drain();

        // Randomized traffic with random backpressure.
        rr_random = 1'b1;
        for (int t = 0; t < 300; t++) begin
            r    = int'($urandom_range(0, 9));
            size = (r == 0) ? 2'b11 : 2'(r % 3);
            a    = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'b01) a[0] = 1'b0;
                else if (size == 2'b10) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 9) == 0) a[31:15] = 17'($urandom_range(1, 131071));
            send(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), a,
                 $urandom, 6'($urandom), 1'b1, acc);
        end
        wait_drain();
        rr_random = 1'b0;
        rr_fixed  = 1'b1;
        @(posedge clk);
        #1;

        // LATENCY=1 instance: word store/load and the 3-cycle issue interval.
        sel = 1'b1;
        @(posedge clk);
        #1;
        send(1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, 6'd5, 1'b1, acc);
        wait_drain();
        check("l1_store_tag", 32'(last_tag), 32'd5);
        send(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 6'd6, 1'b1, acc);
        wait_drain();
        check("l1_load_word", last_rdata, 32'h12345678);
        check("l1_load_tag", 32'(last_tag), 32'd6);
        acc_prev = 0;
        for (int k = 0; k < 4; k++) begin
            send(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 6'(40 + k), 1'b1, acc);
            if (k > 0) check("issue_interval_lat1", 32'(acc - acc_prev), 32'd3);
            acc_prev = acc;
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
